// File: rtl/adder_core.sv
// ---------------------------------------------------------------------------
// adder_core
//   Registered signed two's-complement adder with carry, overflow and zero
//   status. Free-running pipeline of LATENCY (1 or 2) stages with optional
//   saturation of the result on signed overflow.
//
// Parameters
//   WIDTH     operand/result width in bits
//   LATENCY   clock edges from operand sample to result (1 or 2)
//   SATURATE  0 = wrap-around result, 1 = clamp to signed max/min on overflow
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   a, b       signed operands
//   c          registered sum (wrapped or saturated)
//   carry_out  unsigned carry out of bit WIDTH-1 of the raw sum
//   overflow   signed overflow of the raw sum (before saturation)
//   zero       high when c == 0 (after saturation)
//   c_valid    high once the pipeline holds a result sampled after reset
// ---------------------------------------------------------------------------
module adder_core #(
    parameter int WIDTH    = 32,
    parameter int LATENCY  = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             c_valid
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow both operands share a sign, so the sign of a alone picks
    // the clamp direction.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ovf,
                                                  input logic             neg);
        if ((SATURATE != 0) && ovf) begin
            return neg ? SMIN : SMAX;
        end
        return raw;
    endfunction

    // ---- stage 0: combinational raw sum and status ----
    logic [WIDTH:0] sum_p0;
    logic           ovf_p0;
    logic           neg_p0;

    assign sum_p0 = {1'b0, a} + {1'b0, b};
    assign ovf_p0 = (a[WIDTH-1] == b[WIDTH-1]) && (sum_p0[WIDTH-1] != a[WIDTH-1]);
    assign neg_p0 = a[WIDTH-1];

    generate
        if (LATENCY == 1) begin : g_lat1
            logic [WIDTH-1:0] res_p0;
            logic signed [WIDTH-1:0] c_p1;
            logic             carry_p1;
            logic             ovf_p1;
            logic             zero_p1;
            logic             vld_p1;

            assign res_p0 = saturate(sum_p0[WIDTH-1:0], ovf_p0, neg_p0);

            // ---- stage 1: final result and flags ----
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    c_p1     <= '0;
                    carry_p1 <= 1'b0;
                    ovf_p1   <= 1'b0;
                    zero_p1  <= 1'b1;
                    vld_p1   <= 1'b0;
                end else begin
                    c_p1     <= res_p0;
                    carry_p1 <= sum_p0[WIDTH];
                    ovf_p1   <= ovf_p0;
                    zero_p1  <= (res_p0 == '0);
                    vld_p1   <= 1'b1;
                end
            end

            assign c         = c_p1;
            assign carry_out = carry_p1;
            assign overflow  = ovf_p1;
            assign zero      = zero_p1;
            assign c_valid   = vld_p1;
        end else if (LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] sum_p1;
            logic             carry_p1;
            logic             ovf_p1;
            logic             neg_p1;
            logic             vld_p1;
            logic [WIDTH-1:0] res_p1;
            logic signed [WIDTH-1:0] c_p2;
            logic             carry_p2;
            logic             ovf_p2;
            logic             zero_p2;
            logic             vld_p2;

            // ---- stage 1: raw sum and flags ----
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum_p1   <= '0;
                    carry_p1 <= 1'b0;
                    ovf_p1   <= 1'b0;
                    neg_p1   <= 1'b0;
                    vld_p1   <= 1'b0;
                end else begin
                    sum_p1   <= sum_p0[WIDTH-1:0];
                    carry_p1 <= sum_p0[WIDTH];
                    ovf_p1   <= ovf_p0;
                    neg_p1   <= neg_p0;
                    vld_p1   <= 1'b1;
                end
            end

            assign res_p1 = saturate(sum_p1, ovf_p1, neg_p1);

            // ---- stage 2: saturation and zero detect ----
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    c_p2     <= '0;
                    carry_p2 <= 1'b0;
                    ovf_p2   <= 1'b0;
                    zero_p2  <= 1'b1;
                    vld_p2   <= 1'b0;
                end else begin
                    c_p2     <= res_p1;
                    carry_p2 <= carry_p1;
                    ovf_p2   <= ovf_p1;
                    zero_p2  <= (res_p1 == '0);
                    vld_p2   <= vld_p1;
                end
            end

            assign c         = c_p2;
            assign carry_out = carry_p2;
            assign overflow  = ovf_p2;
            assign zero      = zero_p2;
            assign c_valid   = vld_p2;
        end else begin : g_bad_latency
            $error("adder_core: LATENCY must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_adder_core.sv
module tb_adder_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] c10, c11, c20, c21;
    logic        cy10, cy11, cy20, cy21;
    logic        ov10, ov11, ov20, ov21;
    logic        z10, z11, z20, z21;
    logic        v10, v11, v20, v21;

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    adder_core #(.WIDTH(32), .LATENCY(1), .SATURATE(0)) u_l1s0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c10), .carry_out(cy10),
        .overflow(ov10), .zero(z10), .c_valid(v10));
    adder_core #(.WIDTH(32), .LATENCY(1), .SATURATE(1)) u_l1s1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c11), .carry_out(cy11),
        .overflow(ov11), .zero(z11), .c_valid(v11));
    adder_core #(.WIDTH(32), .LATENCY(2), .SATURATE(0)) u_l2s0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c20), .carry_out(cy20),
        .overflow(ov20), .zero(z20), .c_valid(v20));
    adder_core #(.WIDTH(32), .LATENCY(2), .SATURATE(1)) u_l2s1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c21), .carry_out(cy21),
        .overflow(ov21), .zero(z21), .c_valid(v21));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    endtask

    // Result plus the three flags of one instance; zero follows the expected c.
    task automatic check_out(input string tag, input logic [31:0] gc, input logic gcy,
                             input logic gov, input logic gz, input logic [31:0] ec,
                             input logic ecy, input logic eov);
        check({tag, "_c"}, gc, ec);
        check({tag, "_carry"}, {31'b0, gcy}, {31'b0, ecy});
        check({tag, "_ovf"}, {31'b0, gov}, {31'b0, eov});
        check({tag, "_zero"}, {31'b0, gz}, {31'b0, (ec == 32'd0)});
    endtask

    // Hold one operand pair for two edges: LATENCY=1 results after the first,
    // LATENCY=2 results after the second (LATENCY=1 must still hold its value).
    task automatic vec(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] e_wrap, input logic [31:0] e_sat,
                       input logic ecy, input logic eov);
        @(negedge clk);
        a = ai;
        b = bi;
        @(posedge clk); #1;
        check_out({tag, "_l1s0"}, c10, cy10, ov10, z10, e_wrap, ecy, eov);
        check_out({tag, "_l1s1"}, c11, cy11, ov11, z11, e_sat, ecy, eov);
        @(posedge clk); #1;
        check({tag, "_l1s0_hold"}, c10, e_wrap);
        check_out({tag, "_l2s0"}, c20, cy20, ov20, z20, e_wrap, ecy, eov);
        check_out({tag, "_l2s1"}, c21, cy21, ov21, z21, e_sat, ecy, eov);
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 32'd7;
        b     = 32'd9;

        // reset held for two edges
        @(posedge clk);
        @(posedge clk); #1;
        check_out("rst_l1s0", c10, cy10, ov10, z10, 32'd0, 1'b0, 1'b0);
        check_out("rst_l2s1", c21, cy21, ov21, z21, 32'd0, 1'b0, 1'b0);
        check("rst_v10", {31'b0, v10}, 32'd0);
        check("rst_v20", {31'b0, v20}, 32'd0);

        // release: valid rises LATENCY edges later
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel1_v10", {31'b0, v10}, 32'd1);
        check("rel1_c10", c10, 32'd16);
        check("rel1_v20", {31'b0, v20}, 32'd0);
        check("rel1_c20", c20, 32'd0);
        @(posedge clk); #1;
        check("rel2_v20", {31'b0, v20}, 32'd1);
        check("rel2_v21", {31'b0, v21}, 32'd1);
        check("rel2_c20", c20, 32'd16);

        //   tag       a             b             wrap          sat           cy    ov
        vec("add1",  32'd15,       32'd20,       32'd35,       32'd35,       1'b0, 1'b0);
        vec("add2",  32'd34,       32'd45,       32'd79,       32'd79,       1'b0, 1'b0);
        vec("m1p1",  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b1, 1'b0);
        vec("m5p3",  32'hFFFFFFFB, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0);
        vec("posov", 32'h7FFFFFFF, 32'd1,        32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1);
        vec("negov", 32'h80000000, 32'h80000000, 32'd0,        32'h80000000, 1'b1, 1'b1);
        vec("negov2",32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1);
        vec("maxm1", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFE, 32'h7FFFFFFE, 1'b1, 1'b0);

        // back-to-back operands, one pair per cycle
        @(negedge clk);
        a = 32'd1; b = 32'd1;
        @(posedge clk);
        @(negedge clk);
        a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        check("b2b_l2_2", c20, 32'd2);
        check("b2b_l1_4", c10, 32'd4);
        @(negedge clk);
        a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        check("b2b_l2_4", c20, 32'd4);
        check("b2b_l1_6", c10, 32'd6);
        @(posedge clk); #1;
        check("b2b_l2_6", c20, 32'd6);

        // reset mid-stream discards in-flight results
        @(negedge clk);
        a = 32'd5; b = 32'd5;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_out("mrst_l2s0", c20, cy20, ov20, z20, 32'd0, 1'b0, 1'b0);
        check("mrst_c10", c10, 32'd0);
        check("mrst_v10", {31'b0, v10}, 32'd0);
        check("mrst_v20", {31'b0, v20}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrel1_c20", c20, 32'd0);
        check("mrel1_v20", {31'b0, v20}, 32'd0);
        check("mrel1_c10", c10, 32'd10);
        check("mrel1_v10", {31'b0, v10}, 32'd1);
        @(posedge clk); #1;
        check("mrel2_c20", c20, 32'd10);
        check("mrel2_v20", {31'b0, v20}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_core.md
Name: adder_core

Overview:
- Synchronous signed integer adder: registers the sum of two WIDTH-bit two's-complement operands every clock.
- Also provides carry, overflow and zero status flags.
- Generic arithmetic leaf inside datapath blocks.
- Fixed-latency, free-running pipeline with no input handshake; a valid output marks when results are meaningful after reset.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement; matches SV integer).
- LATENCY, 1, clock cycles from operand sample to result; legal values 1 or 2.
- SATURATE, 0, 0 = wrap-around result; 1 = clamp to signed max/min on overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- c  output  WIDTH  signed registered sum.
- carry_out  output  1  unsigned carry out of bit WIDTH-1.
- overflow  output  1  signed overflow occurred (before saturation).
- zero  output  1  c == 0.
- c_valid  output  1  high once the pipeline holds a result sampled after reset release.

Behaviour:
- One clock domain and one reset. Reset is synchronous and active-low.
- All state updates occur on the rising edge of clk only. No combinational path from a/b to any output.
- Reset (rst_n low at a rising edge):
  - c = 0, carry_out = 0, overflow = 0, zero = 1, c_valid = 0.
  - All internal pipeline stages are cleared.
  - Reset asserted mid-operation discards in-flight results.
- Arithmetic at the sampling edge:
  - Compute the WIDTH+1-bit sum {0,a} + {0,b}. carry_out = bit WIDTH.
  - overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
- Result selection:
  - SATURATE = 0: c = sum[WIDTH-1:0], wrapping modulo 2^WIDTH.
  - SATURATE = 1 and overflow: c = 2^(WIDTH-1)-1 when both operands are non-negative, else -2^(WIDTH-1).
  - The flags always report the raw sum, independent of saturation.
- zero reflects the final c value, after any saturation.
- Latency:
  - LATENCY = 1: operands sampled at edge N appear on c/flags after edge N.
  - LATENCY = 2: the raw sum and flags are registered in stage 1; saturation and zero are computed in stage 2; results appear after edge N+1.
  - Throughput is one result per cycle in both modes, with a new operand pair accepted every cycle.
- c_valid: shift register of depth LATENCY, filled with 1s from the first edge with rst_n high. It goes high LATENCY edges after reset release and stays high until the next reset.
- Outputs hold their value while a/b are unchanged; a constant input produces a constant output.
- An illegal LATENCY value causes an elaboration-time error.

Test Plan:
- Reset: hold rst_n low for 2 cycles with a=7, b=9 -> c=0, zero=1, c_valid=0. After release, c_valid rises after LATENCY edges.
- Basic sequence: a=15, b=20 for 10 ns, then a=34, b=45, with a 10 ns clock period -> c=35 then c=79, each one edge after the operands; no flags set.
- Signed and carry: a=-1, b=1 -> c=0, zero=1, carry_out=1, overflow=0. Then a=-5, b=3 -> c=-2.
- Overflow with SATURATE=0: a=0x7FFFFFFF, b=1 -> c=0x80000000, overflow=1, carry_out=0. Then a=0x80000000, b=0x80000000 -> c=0, overflow=1, carry_out=1, zero=1.
- Overflow with SATURATE=1: the same two operand pairs -> c=0x7FFFFFFF, then c=0x80000000, with overflow=1 both times and zero=0.
- LATENCY=2 back-to-back: drive a new pair every cycle (1+1, 2+2, 3+3) -> c = 2, 4, 6 on consecutive cycles, each two edges after its operands. Assert rst_n low mid-stream -> outputs clear at the next edge.
